// File: rtl/oled_power_sequencer.sv
// OLED panel power sequencer: orders pmoden / res_n / vccen for power-up and
// power-down, timing each phase in microseconds and handshaking with the command engine.
module oled_power_sequencer #(
    parameter int T_PMOD_US = 20000,
    parameter int T_RES_US  = 3,
    parameter int T_VCC_US  = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic us_tick,
    input  logic power_on,
    input  logic power_off,
    input  logic init_done,
    input  logic off_done,
    output logic pmoden,
    output logic res_n,
    output logic vccen,
    output logic init_req,
    output logic off_req,
    output logic ready,
    output logic busy
);

    localparam int T_M1  = (T_PMOD_US > T_RES_US) ? T_PMOD_US : T_RES_US;
    localparam int T_M2  = (T_M1 > T_VCC_US) ? T_M1 : T_VCC_US;
    localparam int DLY_W = $clog2(((T_M2 > 1) ? T_M2 : 1) + 1);

    // A zero delay still waits for one tick, so it loads as 1.
    localparam logic [DLY_W-1:0] LD_PMOD = DLY_W'((T_PMOD_US == 0) ? 1 : T_PMOD_US);
    localparam logic [DLY_W-1:0] LD_RES  = DLY_W'((T_RES_US  == 0) ? 1 : T_RES_US);
    localparam logic [DLY_W-1:0] LD_VCC  = DLY_W'((T_VCC_US  == 0) ? 1 : T_VCC_US);

    typedef enum logic [3:0] {
        S_OFF,
        S_PMOD_WAIT,
        S_RES_LOW,
        S_RES_HIGH,
        S_INIT,
        S_VCC_WAIT,
        S_ON,
        S_DISP_OFF,
        S_VCC_OFF_WAIT
    } state_t;

    state_t           state_q, state_d;
    logic [DLY_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             done_tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_OFF;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q | (power_off & (state_q != S_OFF));
        done_tick = us_tick && (cnt_q == DLY_W'(1));
        if (us_tick && !done_tick)
            cnt_d = cnt_q - DLY_W'(1);

        case (state_q)
            S_OFF: begin
                if (power_on && !power_off) begin
                    state_d = S_PMOD_WAIT;
                    cnt_d   = LD_PMOD;
                end
            end
            S_PMOD_WAIT: begin
                if (pend_d) state_d = S_OFF;
                else if (done_tick) begin
                    state_d = S_RES_LOW;
                    cnt_d   = LD_RES;
                end
            end
            S_RES_LOW: begin
                if (pend_d) state_d = S_OFF;
                else if (done_tick) begin
                    state_d = S_RES_HIGH;
                    cnt_d   = LD_RES;
                end
            end
            S_RES_HIGH: begin
                if (pend_d) state_d = S_OFF;
                else if (done_tick) state_d = S_INIT;
            end
            S_INIT: begin
                // An abort during init still lets the stream finish before display-off.
                if (init_done) begin
                    if (pend_d) state_d = S_DISP_OFF;
                    else begin
                        state_d = S_VCC_WAIT;
                        cnt_d   = LD_VCC;
                    end
                end
            end
            S_VCC_WAIT: begin
                if (pend_d) state_d = S_DISP_OFF;
                else if (done_tick) state_d = S_ON;
            end
            S_ON: begin
                if (pend_d) state_d = S_DISP_OFF;
            end
            S_DISP_OFF: begin
                if (off_done) begin
                    state_d = S_VCC_OFF_WAIT;
                    cnt_d   = LD_VCC;
                end
            end
            S_VCC_OFF_WAIT: begin
                if (done_tick) state_d = S_OFF;
            end
            default: state_d = S_OFF;
        endcase

        if (state_d == S_OFF)
            pend_d = 1'b0;
    end

    always_comb begin
        pmoden   = (state_q != S_OFF);
        res_n    = (state_q != S_OFF) && (state_q != S_RES_LOW);
        vccen    = (state_q == S_VCC_WAIT) || (state_q == S_ON) || (state_q == S_DISP_OFF);
        init_req = (state_q == S_INIT);
        off_req  = (state_q == S_DISP_OFF);
        ready    = (state_q == S_ON);
        busy     = (state_q != S_OFF) && (state_q != S_ON);
    end

endmodule

// File: tb/tb_oled_power_sequencer.sv
// Randomized bench for oled_power_sequencer against a table-driven phase model.
module tb_oled_power_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1, us_tick = 1'b0, power_on = 1'b0, power_off = 1'b0;
    logic init_done = 1'b0, off_done = 1'b0;
    logic pmoden, res_n, vccen, init_req, off_req, ready, busy;

    always #5 clk = ~clk;

    oled_power_sequencer #(.T_PMOD_US(4), .T_RES_US(2), .T_VCC_US(5)) dut (
        .clk(clk), .rst(rst), .us_tick(us_tick), .power_on(power_on),
        .power_off(power_off), .init_done(init_done), .off_done(off_done),
        .pmoden(pmoden), .res_n(res_n), .vccen(vccen), .init_req(init_req),
        .off_req(off_req), .ready(ready), .busy(busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Phase table: 0 OFF, 1 PMOD wait, 2 reset low, 3 reset high, 4 init,
    // 5 VCC wait, 6 on, 7 display off, 8 VCC off wait.
    // Output bits: {pmoden, res_n, vccen, init_req, off_req, ready, busy}.
    int         dur  [9] = '{0, 4, 2, 2, 0, 5, 0, 0, 5};
    logic [6:0] outs [9] = '{7'b0000000, 7'b1100001, 7'b1000001, 7'b1100001,
                             7'b1101001, 7'b1110001, 7'b1110010, 7'b1110101,
                             7'b1100001};
    int ph = 0, rem = 0;
    bit pend = 0;

    function automatic bit timed(input int p);
        return dur[p] > 0;
    endfunction

    task automatic model_step();
        int nph;
        bit pn;
        if (rst) begin
            ph = 0; rem = 0; pend = 0;
            return;
        end
        pn  = pend || (power_off && ph != 0);
        nph = ph;
        if (ph == 0) begin
            if (power_on && !power_off) nph = 1;
        end else if (pn && ph >= 1 && ph <= 3) nph = 0;
        else if (pn && (ph == 5 || ph == 6)) nph = 7;
        else if (ph == 4) begin
            if (init_done) nph = pn ? 7 : 5;
        end else if (ph == 7) begin
            if (off_done) nph = 8;
        end else if (timed(ph) && us_tick) begin
            rem--;
            if (rem == 0) nph = (ph == 8) ? 0 : ph + 1;
        end
        if (nph != ph && timed(nph)) rem = dur[nph];
        pend = (nph == 0) ? 1'b0 : pn;
        ph   = nph;
    endtask

    int cyc = 0;
    bit tick_stuck = 0;

    task automatic step(input bit r, input bit pon, input bit poff, input bit id, input bit od);
        rst = r; power_on = pon; power_off = poff; init_done = id; off_done = od;
        us_tick = tick_stuck ? 1'b1 : (cyc % 3 == 0);
        cyc++;
        @(posedge clk);
        model_step();
        #1;
        chk($sformatf("outs@%0d", cyc), {25'd0, pmoden, res_n, vccen, init_req, off_req, ready, busy},
            {25'd0, outs[ph]});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    initial begin
        #1;
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0);
        // Full power-up, then edge cases while on, then power-down.
        step(0, 1, 0, 0, 0);
        idle(40);
        idle(7);
        step(0, 0, 0, 1, 0);
        idle(20);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        idle(3);
        step(0, 0, 1, 0, 0);
        idle(10);
        step(0, 0, 0, 0, 1);
        idle(20);
        // Abort in reset-low, then restart.
        step(0, 1, 0, 0, 0);
        idle(14);
        step(0, 0, 1, 0, 0);
        idle(3);
        step(0, 1, 0, 0, 0);
        idle(40);
        // Abort during init.
        step(0, 0, 1, 0, 0);
        idle(5);
        step(0, 0, 0, 1, 0);
        idle(5);
        step(0, 0, 0, 0, 1);
        idle(20);
        // Simultaneous on/off from OFF.
        step(0, 1, 1, 0, 0);
        idle(3);
        // Reset in VCC wait.
        step(0, 1, 0, 0, 0);
        idle(40);
        step(0, 0, 0, 1, 0);
        idle(4);
        step(1, 0, 0, 0, 0);
        idle(3);
        // us_tick stuck high.
        tick_stuck = 1;
        step(0, 1, 0, 0, 0);
        idle(12);
        step(0, 0, 0, 1, 0);
        idle(8);
        step(0, 0, 1, 0, 0);
        idle(2);
        step(0, 0, 0, 0, 1);
        idle(8);
        tick_stuck = 0;
        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            bit r, pon, poff, id, od;
            if (i % 700 == 350) tick_stuck = ~tick_stuck;
            r    = ($urandom_range(0, 399) == 0);
            pon  = ($urandom_range(0, 24) == 0);
            poff = ($urandom_range(0, 59) == 0);
            id   = (ph == 4) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 49) == 0);
            od   = (ph == 7) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 49) == 0);
            step(r, pon, poff, id, od);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
